i2s_rx_deserializer: RTL



---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_rx_deserializer_if.sv | 26 ++
 rtl/i2s_sync_edge.sv | 32 +++
 rtl/i2s_rx_deserializer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S receive path.
package i2s_pkg;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// Connection bundle between the I2S pins/enable source and the receive deserializer.
interface i2s_rx_deserializer_if #(
  parameter int OUT_WIDTH = 32
);

  logic                 enable;
  logic                 i2s_bclk;
  logic                 i2s_lrclk;
  logic                 i2s_sdata;
  logic [OUT_WIDTH-1:0] sample_data;
  logic                 sample_valid;
  logic                 sample_is_right;
  logic                 frame_error;
  logic                 sync_lost;

  modport master (
    output enable, i2s_bclk, i2s_lrclk, i2s_sdata,
    input  sample_data, sample_valid, sample_is_right, frame_error, sync_lost
  );

  modport slave (
    input  enable, i2s_bclk, i2s_lrclk, i2s_sdata,
    output sample_data, sample_valid, sample_is_right, frame_error, sync_lost
  );

endinterface

// File: rtl/i2s_sync_edge.sv
// Two-flop synchronizer for one asynchronous I2S line, plus a previous-value
// flop that yields rise and change strobes in the clk domain.
module i2s_sync_edge
  import i2s_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic change_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o   = sync_q[SYNC_STAGES-1];
  assign rise_o   = sync_o & ~prev_q;
  assign change_o = sync_o ^ prev_q;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receive front end: oversamples bclk/lrclk/sdata, deserializes MSB-first
// channel words and emits sign-extended samples with a one-cycle strobe.
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = 24,
  parameter int OUT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  i2s_rx_deserializer_if.slave bus
);

  localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_WIDTH);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic bclk_rise, lrclk_sync, lrclk_change, sdata_sync, ws_edge;
  logic unused_bclk_sync, unused_bclk_change;
  logic unused_lrclk_rise, unused_sdata_rise, unused_sdata_change;

  rx_state_e               state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic                    channel_q, channel_d;
  logic                    ws_pend_q, ws_pend_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic                    done_q, done_d;
  logic                    done_ch_q, done_ch_d;
  logic                    ferr_q, ferr_d;
  logic [OUT_WIDTH-1:0]    sample_data_q, sample_data_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    sample_is_right_q, sample_is_right_d;
  logic                    frame_error_q, frame_error_d;
  logic                    sync_lost_q, sync_lost_d;

  i2s_sync_edge u_bclk_sync (
    .clk(clk), .rst(rst), .d_i(bus.i2s_bclk),
    .sync_o(unused_bclk_sync), .rise_o(bclk_rise), .change_o(unused_bclk_change)
  );

  i2s_sync_edge u_lrclk_sync (
    .clk(clk), .rst(rst), .d_i(bus.i2s_lrclk),
    .sync_o(lrclk_sync), .rise_o(unused_lrclk_rise), .change_o(lrclk_change)
  );

  i2s_sync_edge u_sdata_sync (
    .clk(clk), .rst(rst), .d_i(bus.i2s_sdata),
    .sync_o(sdata_sync), .rise_o(unused_sdata_rise), .change_o(unused_sdata_change)
  );

  // A word-select change only counts at the bclk rise that first sees it.
  assign ws_edge = bclk_rise & (ws_pend_q | lrclk_change);

  // NOTE: every next-state signal gets a default first, so no path through the block can infer a latch.
  always_comb begin
    state_d           = state_q;
    count_d           = count_q;
    shift_d           = shift_q;
    channel_d         = channel_q;
    to_cnt_d          = to_cnt_q;
    done_ch_d         = done_ch_q;
    sample_data_d     = sample_data_q;
    sample_is_right_d = sample_is_right_q;
    sync_lost_d       = sync_lost_q;
    done_d            = 1'b0;
    ferr_d            = 1'b0;
    sample_valid_d    = 1'b0;
    frame_error_d     = ferr_q & bus.enable;
    ws_pend_d         = bclk_rise ? 1'b0 : (ws_pend_q | lrclk_change);

    // Shift register is stable here: bclk rises are at least 4 clk apart.
    if (done_q && bus.enable) begin
      sample_data_d     = OUT_WIDTH'($signed(shift_q));
      sample_is_right_d = (done_ch_q == CH_RIGHT);
      sample_valid_d    = 1'b1;
    end

    if (!bus.enable) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      if (bclk_rise)                to_cnt_d = '0;
      else if (to_cnt_q != TO_LIMIT) to_cnt_d = to_cnt_q + TO_W'(1);

      case (state_q)
        IDLE: begin
          if (ws_edge) begin
            channel_d   = lrclk_sync;
            count_d     = '0;
            state_d     = SHIFT;
            sync_lost_d = 1'b0;
          end
        end
        SHIFT: begin
          if (bclk_rise) begin
            if (count_q < CNT_FULL) begin
              shift_d = (shift_q << 1) | SAMPLE_WIDTH'(sdata_sync);
              count_d = count_q + CNT_W'(1);
              if (count_d == CNT_FULL) begin
                done_d    = 1'b1;
                done_ch_d = channel_q;
              end
            end
            if (ws_edge) begin
              ferr_d    = (count_d < CNT_FULL);
              channel_d = lrclk_sync;
              count_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (to_cnt_d == TO_LIMIT) begin
        sync_lost_d = 1'b1;
        state_d     = IDLE;
        count_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      count_q           <= '0;
      shift_q           <= '0;
      channel_q         <= CH_LEFT;
      ws_pend_q         <= 1'b0;
      to_cnt_q          <= '0;
      done_q            <= 1'b0;
      done_ch_q         <= CH_LEFT;
      ferr_q            <= 1'b0;
      sample_data_q     <= '0;
      sample_valid_q    <= 1'b0;
      sample_is_right_q <= 1'b0;
      frame_error_q     <= 1'b0;
      sync_lost_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      count_q           <= count_d;
      shift_q           <= shift_d;
      channel_q         <= channel_d;
      ws_pend_q         <= ws_pend_d;
      to_cnt_q          <= to_cnt_d;
      done_q            <= done_d;
      done_ch_q         <= done_ch_d;
      ferr_q            <= ferr_d;
      sample_data_q     <= sample_data_d;
      sample_valid_q    <= sample_valid_d;
      sample_is_right_q <= sample_is_right_d;
      frame_error_q     <= frame_error_d;
      sync_lost_q       <= sync_lost_d;
    end
  end

  assign bus.sample_data     = sample_data_q;
  assign bus.sample_valid    = sample_valid_q;
  assign bus.sample_is_right = sample_is_right_q;
  assign bus.frame_error     = frame_error_q;
  assign bus.sync_lost       = sync_lost_q;

endmodule
